dcache_mem_dummy_responder: RTL and testbench

- Behavioural memory-side responder for the CPU/D-cache dummy traffic interface (the `*_data1` port group).
- Accepts write, read and flush commands from an initiator over a valid/ready handshake and stores write data in an internal word array.
- Returns read data with a configurable, deterministic latency and keeps transaction and protocol-check status for benches and on-board debug.

---
 rtl/dcache_mem_dummy_responder.sv | 104 ++++++++++
 tb/tb_dcache_mem_dummy_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dcache_mem_dummy_responder.sv
// dcache_mem_dummy_responder: memory-side responder for the *_data1 dummy traffic port with fixed command latencies.
// Define DCACHE_MEM_DUMMY_RAND_LAT_EN to add 0-7 LFSR-driven extra cycles per command.
module dcache_mem_dummy_responder #(
  parameter int MEM_AW = 10,
  parameter int WR_LAT = 4,
  parameter int RD_LAT = 6,
  parameter int FL_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_data_wr1,
  output logic [31:0] mem_data_rd1,
  input  logic [27:0] mem_data_addr1,
  input  logic        mem_rw_data1,
  input  logic        mem_valid_data1,
  input  logic        flush,
  output logic        mem_ready_data1,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [15:0] fl_count,
  output logic        proto_err
);
  localparam logic [15:0] WL = 16'(WR_LAT < 1 ? 0 : WR_LAT - 1);
  localparam logic [15:0] RL = 16'(RD_LAT < 1 ? 0 : RD_LAT - 1);
  localparam logic [15:0] FL = 16'(FL_LAT < 1 ? 0 : FL_LAT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {C_WR, C_RD, C_FL} cmd_t;
  state_t      state;
  cmd_t        cmd;
  cmd_t        cmd_in;
  logic [27:0] addr_q;
  logic [31:0] data_q;
  logic        rw_q;
  logic        fl_q;
  logic [15:0] cnt;
  logic [15:0] lat_in;
  logic [15:0] extra;
  logic [31:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  assign idx    = addr_q[MEM_AW-1:0];
  assign cmd_in = flush ? C_FL : mem_rw_data1 ? C_WR : C_RD;
  assign lat_in = (cmd_in == C_FL ? FL : cmd_in == C_WR ? WL : RL) + extra;
`ifdef DCACHE_MEM_DUMMY_RAND_LAT_EN
  logic [7:0] lfsr;
  assign extra = {13'd0, lfsr[2:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 8'hA5;
    else if (state == IDLE && mem_valid_data1) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
  assign extra = 16'd0;
`endif
  // Array is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk)
    if (state == BUSY && cnt == 16'd0 && cmd == C_WR) mem[idx] <= data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cmd             <= C_RD;
      addr_q          <= '0;
      data_q          <= '0;
      rw_q            <= 1'b0;
      fl_q            <= 1'b0;
      cnt             <= '0;
      mem_data_rd1    <= '0;
      mem_ready_data1 <= 1'b0;
      busy            <= 1'b0;
      wr_count        <= '0;
      rd_count        <= '0;
      fl_count        <= '0;
      proto_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_valid_data1) begin
          state  <= BUSY;
          cmd    <= cmd_in;
          addr_q <= mem_data_addr1;
          data_q <= mem_data_wr1;
          rw_q   <= mem_rw_data1;
          fl_q   <= flush;
          cnt    <= lat_in;
          busy   <= 1'b1;
        end
        BUSY: begin
          if (!mem_valid_data1 || flush != fl_q || mem_rw_data1 != rw_q || mem_data_addr1 != addr_q ||
              (cmd == C_WR && mem_data_wr1 != data_q)) proto_err <= 1'b1;
          if (cnt == 16'd0) begin
            state           <= RESP;
            mem_ready_data1 <= 1'b1;
            if (cmd == C_RD) mem_data_rd1 <= mem[idx];
          end else cnt <= cnt - 16'd1;
        end
        default: begin
          state           <= IDLE;
          mem_ready_data1 <= 1'b0;
          busy            <= 1'b0;
          wr_count        <= wr_count + 16'(cmd == C_WR);
          rd_count        <= rd_count + 16'(cmd == C_RD);
          fl_count        <= fl_count + 16'(cmd == C_FL);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_mem_dummy_responder.sv
// tb_dcache_mem_dummy_responder: directed stimulus with a response scoreboard for dcache_mem_dummy_responder.
module tb_dcache_mem_dummy_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_data_wr1 = '0;
  logic [31:0] mem_data_rd1;
  logic [27:0] mem_data_addr1 = '0;
  logic        mem_rw_data1 = 1'b0;
  logic        mem_valid_data1 = 1'b0;
  logic        flush = 1'b0;
  logic        mem_ready_data1;
  logic        busy;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] fl_count;
  logic        proto_err;
  typedef struct {int cyc; bit chk; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   idle_at = 0;
  int   cmp = 0;
  int   errs = 0;
  dcache_mem_dummy_responder dut (
    .clk(clk), .rst(rst), .mem_data_wr1(mem_data_wr1), .mem_data_rd1(mem_data_rd1),
    .mem_data_addr1(mem_data_addr1), .mem_rw_data1(mem_rw_data1), .mem_valid_data1(mem_valid_data1),
    .flush(flush), .mem_ready_data1(mem_ready_data1), .busy(busy), .wr_count(wr_count),
    .rd_count(rd_count), .fl_count(fl_count), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && mem_ready_data1) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk) chk("read_data", mem_data_rd1, e.d);
      end
    end
  end
  // Issue a command and wait for its ready; glitch changes addr in the 2nd busy cycle.
  task automatic send(input logic rw, input logic fl, input logic [27:0] a, input logic [31:0] d,
                      input bit chk_d, input logic [31:0] exp_d, input int lat, input bit glitch);
    int cap;
    bit seen;
    exp_t e;
    cap = (cyc + 1 > idle_at) ? cyc + 1 : idle_at;
    mem_valid_data1 = 1'b1;
    mem_rw_data1 = rw;
    flush = fl;
    mem_data_addr1 = a;
    mem_data_wr1 = d;
    e.cyc = cap + lat;
    e.chk = chk_d;
    e.d = exp_d;
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < lat + 40 && !seen; i++) begin
      @(negedge clk);
      if (glitch && cyc == cap + 1) mem_data_addr1 = a + 28'd1;
      seen = mem_ready_data1;
    end
    if (!seen) chk("ready_timeout", 32'(cyc), 32'(cap + lat));
    idle_at = cyc + 2;
  endtask
  task automatic wr(input logic [27:0] a, input logic [31:0] d);
    send(1'b1, 1'b0, a, d, 1'b0, 32'h0, 4, 1'b0);
  endtask
  task automatic rd(input logic [27:0] a, input logic [31:0] d);
    send(1'b0, 1'b0, a, 32'h0, 1'b1, d, 6, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, mem_ready_data1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd", mem_data_rd1, 32'd0);
    chk("rst_counts", {wr_count, rd_count}, 32'd0);
    chk("rst_flcnt_proto", {15'd0, fl_count, proto_err}, 32'd0);
    rst = 1'b0;
    idle_at = 0;
    @(negedge clk);
    wr(28'h5, 32'hDEADBEEF);
    rd(28'h5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_rd_counts", {wr_count, rd_count}, {16'd1, 16'd1});
    wr(28'h403, 32'h1234);
    rd(28'h003, 32'h1234);
    wr(28'h7, 32'hA);
    send(1'b1, 1'b1, 28'h7, 32'hFFFFFFFF, 1'b0, 32'h0, 16, 1'b0);
    rd(28'h7, 32'hA);
    @(negedge clk);
    chk("flush_counts", {fl_count, wr_count}, {16'd1, 16'd3});
    chk("rd_count3", {16'd0, rd_count}, 32'd3);
    for (int i = 0; i < 32; i++) wr(28'h100 + 28'(i), 32'hC0DE0000 | 32'(i));
    for (int i = 0; i < 32; i++) rd(28'h100 + 28'(i), 32'hC0DE0000 | 32'(i));
    @(negedge clk);
    chk("sweep_counts", {wr_count, rd_count}, {16'd35, 16'd35});
    chk("sweep_no_proto", {31'd0, proto_err}, 32'd0);
    wr(28'h10, 32'h1010);
    wr(28'h11, 32'h1111);
    send(1'b0, 1'b0, 28'h10, 32'h0, 1'b1, 32'h1010, 6, 1'b1);
    @(negedge clk);
    chk("proto_set", {31'd0, proto_err}, 32'd1);
    rd(28'h100, 32'hC0DE0000);
    @(negedge clk);
    chk("proto_sticky", {31'd0, proto_err}, 32'd1);
    chk("mid_rd_data_hold", mem_data_rd1, 32'hC0DE0000);
    wr(28'h9, 32'h99);
    mem_valid_data1 = 1'b1;
    mem_rw_data1 = 1'b1;
    mem_data_addr1 = 28'h9;
    mem_data_wr1 = 32'h55;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mem_valid_data1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle_at = 0;
    @(negedge clk);
    chk("midrst_counts", {wr_count, rd_count}, 32'd0);
    chk("midrst_fl_proto_rd", {15'd0, fl_count, proto_err} | mem_data_rd1, 32'd0);
    rd(28'h9, 32'h99);
    mem_valid_data1 = 1'b0;
    @(negedge clk);
    chk("post_rst_counts", {wr_count, rd_count}, {16'd0, 16'd1});
    repeat (30) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
